// File: rtl/neural_drv_pkg.sv
// neural_drv_pkg: shared types and constants for the neural accelerator driver.
//   drv_state_e  - sequencer states (IDLE, START, WAIT, RESP)
//   ACT_*        - activation mode encodings driven on acc_activation_mode
// Optional build macro used by the top: NEURAL_DRV_CHECKSUM_EN.
package neural_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } drv_state_e;

    localparam logic [1:0] ACT_RELU    = 2'd0;
    localparam logic [1:0] ACT_SIGMOID = 2'd1;
    localparam logic [1:0] ACT_TANH    = 2'd2;
    localparam logic [1:0] ACT_LINEAR  = 2'd3;

endpackage

// File: rtl/neural_drv_wbuf.sv
// neural_drv_wbuf: synchronous weight FIFO, fall-through read data.
//   i_clk, i_rst_n      - clock, synchronous active-low reset
//   i_wr_en, i_wr_data  - push (ignored when full)
//   i_rd_en             - pop (ignored when empty)
//   o_rd_data           - head entry, valid whenever !o_empty
//   o_count/full/empty  - occupancy
module neural_drv_wbuf #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 16
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_wr_en,
    input  logic [DATA_W-1:0]          i_wr_data,
    input  logic                       i_rd_en,
    output logic [DATA_W-1:0]          o_rd_data,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full,
    output logic                       o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              w_wr;
    logic              w_rd;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_wr      = i_wr_en && !o_full;
    assign w_rd      = i_rd_en && !o_empty;
    assign o_rd_data = r_mem[r_rd_ptr];

    // Storage is not reset; entries are only observed through the pointers.
    always_ff @(posedge i_clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
    end

    // Power-of-two depth: pointers wrap by natural overflow.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/neural_accel_driver.sv
// neural_accel_driver: initiator-side sequencer for the accelerator
// load/compute interface.
//   i_wt_*        - upstream weight words, buffered and streamed out in IDLE
//   i_job_*       - job request (input sample + activation mode)
//   o_acc_*       - drives the accelerator's weight/input/mode/start pins
//   i_acc_*       - accelerator output_data / compute_done
//   o_res_*       - result port (valid/ready), timeout marker with zero data
//   o_busy, o_wbuf_count, o_wt_checksum - status
// Build macro NEURAL_DRV_CHECKSUM_EN enables the running XOR of streamed
// weights on o_wt_checksum; otherwise that port is tied to zero.
module neural_accel_driver
    import neural_drv_pkg::*;
#(
    parameter int WBUF_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int DATA_W         = 16
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_wt_valid,
    input  logic [DATA_W-1:0]             i_wt_data,
    output logic                          o_wt_ready,
    input  logic                          i_job_valid,
    input  logic [DATA_W-1:0]             i_job_input,
    input  logic [1:0]                    i_job_act,
    output logic                          o_job_ready,
    output logic [DATA_W-1:0]             o_acc_weight_data,
    output logic                          o_acc_weight_load,
    output logic [DATA_W-1:0]             o_acc_input_data,
    output logic [1:0]                    o_acc_activation_mode,
    output logic                          o_acc_compute_start,
    input  logic [DATA_W-1:0]             i_acc_output_data,
    input  logic                          i_acc_compute_done,
    output logic                          o_res_valid,
    output logic [DATA_W-1:0]             o_res_data,
    output logic                          o_res_timeout,
    input  logic                          i_res_ready,
    output logic                          o_busy,
    output logic [$clog2(WBUF_DEPTH):0]   o_wbuf_count,
    output logic [DATA_W-1:0]             o_wt_checksum
);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    drv_state_e        r_state;
    drv_state_e        w_state_nxt;
    logic [TW-1:0]     r_tcnt;
    logic [TW-1:0]     w_tcnt_nxt;
    logic              w_tmo;
    logic [DATA_W-1:0] r_job_in;
    logic [1:0]        r_job_act;
    logic [DATA_W-1:0] r_res_data;
    logic              r_res_to;
    logic              r_armed;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_head;
    logic              w_pop;
    logic              w_job_acc;

    neural_drv_wbuf #(
        .DEPTH  (WBUF_DEPTH),
        .DATA_W (DATA_W)
    ) u_wbuf (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_wr_en   (i_wt_valid),
        .i_wr_data (i_wt_data),
        .i_rd_en   (w_pop),
        .o_rd_data (w_head),
        .o_count   (o_wbuf_count),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign o_wt_ready = !w_full;
    assign w_job_acc  = i_job_valid && o_job_ready;
    assign w_tcnt_nxt = r_tcnt + 1'b1;
    // Timeout fires on the cycle the count would reach TIMEOUT_CYCLES-1,
    // so the result appears exactly TIMEOUT_CYCLES cycles after start.
    assign w_tmo      = (w_tcnt_nxt == TW'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:  if (w_job_acc) w_state_nxt = START;
            START: w_state_nxt = WAIT;
            WAIT:  if (i_acc_compute_done || w_tmo) w_state_nxt = RESP;
            RESP:  if (i_res_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Outputs. Jobs are only taken with an empty buffer, so a pop and an
    // accept never share a cycle. r_armed keeps job_ready low for the
    // cycle right after reset.
    always_comb begin
        o_busy              = (r_state != IDLE);
        o_res_valid         = (r_state == RESP);
        o_acc_compute_start = (r_state == START);
        o_job_ready         = (r_state == IDLE) && w_empty && r_armed;
        w_pop               = (r_state == IDLE) && !w_empty;
    end

    assign o_acc_weight_load     = w_pop;
    assign o_acc_weight_data     = w_pop ? w_head : '0;
    assign o_acc_input_data      = r_job_in;
    assign o_acc_activation_mode = r_job_act;
    assign o_res_data            = r_res_data;
    assign o_res_timeout         = r_res_to;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_armed    <= 1'b0;
            r_job_in   <= '0;
            r_job_act  <= '0;
            r_tcnt     <= '0;
            r_res_data <= '0;
            r_res_to   <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (w_job_acc) begin
                r_job_in  <= i_job_input;
                r_job_act <= i_job_act;
            end
            case (r_state)
                START: r_tcnt <= '0;
                WAIT: begin
                    r_tcnt <= w_tcnt_nxt;
                    // done has priority over a coincident timeout
                    if (i_acc_compute_done) begin
                        r_res_data <= i_acc_output_data;
                        r_res_to   <= 1'b0;
                    end else if (w_tmo) begin
                        r_res_data <= '0;
                        r_res_to   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef NEURAL_DRV_CHECKSUM_EN
    logic [DATA_W-1:0] r_csum;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)       r_csum <= '0;
        else if (w_job_acc) r_csum <= '0;
        else if (w_pop)     r_csum <= r_csum ^ w_head;
    end
    assign o_wt_checksum = r_csum;
`else
    assign o_wt_checksum = '0;
`endif

endmodule

// File: tb/tb_neural_accel_driver.sv
module tb_neural_accel_driver;
    import neural_drv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        wt_valid;
    logic [15:0] wt_data;
    logic        job_valid;
    logic [15:0] job_input;
    logic [1:0]  job_act;
    logic        done;
    logic [15:0] stub_out;
    logic        res_ready;
    logic        res_ready_b;

    logic        wt_ready, job_ready, acc_wl, acc_start, res_valid, res_to, busy;
    logic [15:0] acc_wd, acc_in, res_data, csum;
    logic [1:0]  acc_act;
    logic [4:0]  cnt;

    logic        wt_ready_b, job_ready_b, acc_wl_b, acc_start_b, res_valid_b, res_to_b, busy_b;
    logic [15:0] acc_wd_b, acc_in_b, res_data_b, csum_b;
    logic [1:0]  acc_act_b;
    logic [4:0]  cnt_b;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int nstart = 0;
    logic [15:0] exp_w[$];
    logic [16:0] exp_r[$];
    int          lc[$];
    logic        stub_en;
    logic        stub_pend;
    int          stub_at;

    neural_accel_driver dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wt_valid(wt_valid), .i_wt_data(wt_data), .o_wt_ready(wt_ready),
        .i_job_valid(job_valid), .i_job_input(job_input), .i_job_act(job_act),
        .o_job_ready(job_ready),
        .o_acc_weight_data(acc_wd), .o_acc_weight_load(acc_wl),
        .o_acc_input_data(acc_in), .o_acc_activation_mode(acc_act),
        .o_acc_compute_start(acc_start),
        .i_acc_output_data(stub_out), .i_acc_compute_done(done),
        .o_res_valid(res_valid), .o_res_data(res_data), .o_res_timeout(res_to),
        .i_res_ready(res_ready),
        .o_busy(busy), .o_wbuf_count(cnt), .o_wt_checksum(csum)
    );

    // Short-timeout instance: same stimulus, accelerator never completes.
    neural_accel_driver #(.TIMEOUT_CYCLES(8)) dut_to (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wt_valid(wt_valid), .i_wt_data(wt_data), .o_wt_ready(wt_ready_b),
        .i_job_valid(job_valid), .i_job_input(job_input), .i_job_act(job_act),
        .o_job_ready(job_ready_b),
        .o_acc_weight_data(acc_wd_b), .o_acc_weight_load(acc_wl_b),
        .o_acc_input_data(acc_in_b), .o_acc_activation_mode(acc_act_b),
        .o_acc_compute_start(acc_start_b),
        .i_acc_output_data(16'h5555), .i_acc_compute_done(1'b0),
        .o_res_valid(res_valid_b), .o_res_data(res_data_b), .o_res_timeout(res_to_b),
        .i_res_ready(res_ready_b),
        .o_busy(busy_b), .o_wbuf_count(cnt_b), .o_wt_checksum(csum_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Accelerator stub: done pulse 10 cycles after each start.
    always @(negedge clk) begin
        done = 1'b0;
        if (stub_pend && cyc == stub_at) begin
            done      = 1'b1;
            stub_pend = 1'b0;
        end
        if (acc_start) begin
            stub_pend = stub_en;
            stub_at   = cyc + 10;
        end
    end

    // Weight stream scoreboard
    always @(negedge clk) begin
        #1;
        if (acc_start) nstart++;
        if (acc_wl) begin
            lc.push_back(cyc);
            if (exp_w.size() == 0) chk("wt_unexpected", 1, 0);
            else                   chk("wt_data", acc_wd, exp_w.pop_front());
        end
    end

    // Result scoreboard
    always @(negedge clk) begin
        logic [16:0] e;
        #1;
        if (res_valid && res_ready) begin
            if (exp_r.size() == 0) chk("res_unexpected", 1, 0);
            else begin
                e = exp_r.pop_front();
                chk("res_data", res_data, e[15:0]);
                chk("res_timeout", res_to, e[16]);
            end
        end
    end

    task automatic wr_word(input logic [15:0] d);
        wt_valid = 1'b1;
        wt_data  = d;
        for (int i = 0; i < 100; i++) begin
            if (wt_ready) begin
                exp_w.push_back(d);
                @(negedge clk);
                wt_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk("wr_word_timeout", 0, 1);
        wt_valid = 1'b0;
    endtask

    // Returns at the negedge of the cycle after acceptance (the START cycle).
    task automatic do_job(input logic [15:0] din, input logic [1:0] act);
        job_valid = 1'b1;
        job_input = din;
        job_act   = act;
        for (int i = 0; i < 100; i++) begin
            if (job_ready) begin
                @(negedge clk);
                job_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        chk("job_accept_timeout", 0, 1);
        job_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        chk("idle_timeout", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, r, r8, n0, nres;
        logic wclr, jdone;
        rst_n = 1'b0; wt_valid = 1'b0; wt_data = '0;
        job_valid = 1'b0; job_input = '0; job_act = '0;
        res_ready = 1'b0; res_ready_b = 1'b0;
        stub_en = 1'b1; stub_pend = 1'b0; stub_at = 0; stub_out = 16'hBEEF; done = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_wt_ready", wt_ready, 1);
        chk("rst_job_ready", job_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", cnt, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_start", acc_start, 0);
        chk("rst_wload", acc_wl, 0);
        chk("rst_csum", csum, 0);
        rst_n = 1'b1;

        // Three weights stream back-to-back in order
        lc.delete();
        wr_word(16'h0011); wr_word(16'h0022); wr_word(16'h0033);
        repeat (5) @(negedge clk);
        chk("wt_pulses", lc.size(), 3);
        if (lc.size() == 3) chk("wt_consecutive", lc[2] - lc[0], 2);
        chk("wt_count_drained", cnt, 0);

        // Job with done after 10 cycles; timeout twin expires after 8
        n0 = nstart;
        exp_r.push_back({1'b0, 16'hBEEF});
        do_job(16'h1234, ACT_LINEAR);
        s = cyc;
        chk("start_latency", acc_start, 1);
        chk("acc_input", acc_in, 16'h1234);
        chk("acc_mode", acc_act, ACT_LINEAR);
        r = -1; r8 = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (res_valid_b && r8 < 0) begin
                r8 = cyc - s;
                chk("to_timeout_flag", res_to_b, 1);
                chk("to_data_zero", res_data_b, 0);
            end
            if (res_valid && r < 0) r = cyc - s;
            if (r >= 0 && r8 >= 0) break;
        end
        chk("to_latency", r8, 8);
        chk("done_latency", r, 11);
        chk("res_data_live", res_data, 16'hBEEF);
        chk("res_to_live", res_to, 0);
        chk("start_pulses", nstart - n0, 1);
        res_ready_b = 1'b1;

        // Backpressure: result held, new job not started
        stub_out  = 16'h5A5A;
        job_valid = 1'b1; job_input = 16'h0042; job_act = ACT_RELU;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, 16'hBEEF);
            chk("hold_start", acc_start, 0);
            chk("hold_input", acc_in, 16'h1234);
        end
        res_ready = 1'b1;
        exp_r.push_back({1'b0, 16'h5A5A});
        do_job(16'h0042, ACT_RELU);
        chk("job2_mode", acc_act, ACT_RELU);
        wait_idle();
        chk("res_queue_empty1", exp_r.size(), 0);

        // Fill the buffer while the result port is blocked
        res_ready = 1'b0;
        stub_out  = 16'h0777;
        exp_r.push_back({1'b0, 16'h0777});
        do_job(16'h0003, ACT_SIGMOID);
        for (int i = 0; i < 40 && !res_valid; i++) @(negedge clk);
        chk("fill_in_resp", res_valid, 1);
        for (int i = 0; i < 16; i++) wr_word(16'h0100 + 16'(i));
        chk("full_count", cnt, 16);
        chk("full_ready", wt_ready, 0);
        wt_valid = 1'b1; wt_data = 16'h0110;
        job_valid = 1'b1; job_input = 16'h0004; job_act = ACT_TANH;
        repeat (3) begin
            @(negedge clk);
            chk("full_hold_ready", wt_ready, 0);
            chk("full_job_ready", job_ready, 0);
            chk("full_hold_count", cnt, 16);
        end
        stub_out = 16'h0999;
        exp_r.push_back({1'b0, 16'h0999});
        res_ready = 1'b1;
        jdone = 1'b0; wclr = 1'b0;
        for (int i = 0; i < 100 && !jdone; i++) begin
            if (wt_valid && wt_ready) begin
                exp_w.push_back(wt_data);
                wclr = 1'b1;
            end
            if (job_valid && job_ready) begin
                chk("jr_only_empty", cnt, 0);
                jdone = 1'b1;
            end
            @(negedge clk);
            if (wclr) wt_valid = 1'b0;
            if (jdone) job_valid = 1'b0;
        end
        chk("fill_job_taken", jdone, 1);
        chk("word17_taken", wclr, 1);
        wait_idle();
        chk("wt_queue_empty", exp_w.size(), 0);
        chk("res_queue_empty2", exp_r.size(), 0);

        // Reset during WAIT abandons the job
        stub_out = 16'h0BAD;
        do_job(16'h0055, ACT_RELU);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wt_ready", wt_ready, 1);
        chk("mid_rst_job_ready", job_ready, 0);
        chk("mid_rst_res_valid", res_valid, 0);
        chk("mid_rst_res_data", res_data, 0);
        chk("mid_rst_input", acc_in, 0);
        chk("mid_rst_start", acc_start, 0);
        nres = 0;
        repeat (15) begin
            @(negedge clk);
            if (res_valid) nres++;
        end
        chk("late_done_ignored", nres, 0);
        chk("late_done_busy", busy, 0);

        // Checksum of streamed weights
        wr_word(16'h00F0); wr_word(16'h0F0F);
        repeat (4) @(negedge clk);
`ifdef NEURAL_DRV_CHECKSUM_EN
        chk("checksum", csum, 16'h0FFF);
`else
        chk("checksum_off", csum, 16'h0000);
`endif
        chk("final_wt_queue", exp_w.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
